// File: rtl/line_feed_scheduler.sv
// line_feed_scheduler: credit-based pixel feeder in front of the 3x3 line-buffer
// window engine. Each completed input line takes one line-buffer credit and each
// engine line-done interrupt gives one back. The source is stalled while no buffer
// is free.
module line_feed_scheduler #(
    parameter int unsigned IMG_WIDTH     = 512,
    parameter int unsigned IMG_HEIGHT    = 512,
    parameter int unsigned NUM_LINE_BUFS = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [7:0]                             s_pixel,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    output logic [7:0]                             pix_out,
    output logic                                   pix_out_valid,
    input  logic                                   line_done_intr,
    output logic [$clog2(NUM_LINE_BUFS+1)-1:0]     credits,
    output logic                                   busy,
    output logic                                   frame_done,
    output logic                                   err_overflow
);

    localparam int unsigned CRED_W = $clog2(NUM_LINE_BUFS + 1);
    localparam int unsigned COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned LINE_W = $clog2(IMG_HEIGHT + 1);

    localparam logic [CRED_W-1:0] CRED_MAX     = CRED_W'(NUM_LINE_BUFS);
    localparam logic [COL_W-1:0]  COL_LAST     = COL_W'(IMG_WIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_LAST    = LINE_W'(IMG_HEIGHT - 1);
    localparam logic [LINE_W-1:0] DRAIN_TARGET = LINE_W'(IMG_HEIGHT - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [COL_W-1:0]   col_cnt;
    logic [COL_W-1:0]   col_next;
    logic [LINE_W-1:0]  lines_written;
    logic [LINE_W-1:0]  lines_written_next;
    logic [LINE_W-1:0]  lines_processed;
    logic [LINE_W-1:0]  lines_processed_next;
    logic [CRED_W-1:0]  credits_next;
    logic               err_next;

    logic               accept;
    logic               line_complete;
    logic               intr_seen;
    logic               intr_ok;

    // Handshake and status decode; all depend on registered state, never on s_valid
    // for s_ready.
    assign s_ready       = (state == FEED) && (credits != '0);
    assign busy          = (state == FEED) || (state == DRAIN);
    assign frame_done    = (state == DONE);
    assign pix_out       = s_pixel;
    assign pix_out_valid = s_valid && s_ready;

    // Per-cycle events: pixel accept, line completion, and a credit-returning interrupt.
    // An interrupt at full credits is only legal if a line consumes a credit that cycle.
    assign accept        = pix_out_valid;
    assign line_complete = accept && (col_cnt == COL_LAST);
    assign intr_seen     = line_done_intr && busy;
    assign intr_ok       = intr_seen && ((credits != CRED_MAX) || line_complete);

    // Next-state and counter update logic.
    always_comb begin
        state_next           = state;
        col_next             = col_cnt;
        lines_written_next   = lines_written;
        lines_processed_next = lines_processed;
        credits_next         = credits + CRED_W'(intr_ok) - CRED_W'(line_complete);
        err_next             = err_overflow;

        if (accept) begin
            col_next = line_complete ? '0 : col_cnt + COL_W'(1);
        end
        if (line_complete) begin
            lines_written_next = lines_written + LINE_W'(1);
        end
        if (intr_ok) begin
            lines_processed_next = lines_processed + LINE_W'(1);
        end
        if (intr_seen && !intr_ok) begin
            err_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_next           = FEED;
                    col_next             = '0;
                    lines_written_next   = '0;
                    lines_processed_next = '0;
                    credits_next         = CRED_MAX;
                end
            end
            FEED: begin
                if (line_complete && (lines_written == LINE_LAST)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (lines_processed_next >= DRAIN_TARGET) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            col_cnt         <= '0;
            lines_written   <= '0;
            lines_processed <= '0;
            credits         <= CRED_MAX;
            err_overflow    <= 1'b0;
        end else begin
            state           <= state_next;
            col_cnt         <= col_next;
            lines_written   <= lines_written_next;
            lines_processed <= lines_processed_next;
            credits         <= credits_next;
            err_overflow    <= err_next;
        end
    end

endmodule

// File: tb/tb_line_feed_scheduler.sv
// Directed bench for line_feed_scheduler with an 8x6 image and 4 line buffers.
module tb_line_feed_scheduler;

    localparam int unsigned W = 8;
    localparam int unsigned H = 6;
    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] s_pixel;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] pix_out;
    logic       pix_out_valid;
    logic       line_done_intr;
    logic [2:0] credits;
    logic       busy;
    logic       frame_done;
    logic       err_overflow;

    int errors  = 0;
    int checks  = 0;
    int acc_cnt = 0;
    int base;

    line_feed_scheduler #(
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H),
        .NUM_LINE_BUFS(N)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .s_pixel       (s_pixel),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .pix_out       (pix_out),
        .pix_out_valid (pix_out_valid),
        .line_done_intr(line_done_intr),
        .credits       (credits),
        .busy          (busy),
        .frame_done    (frame_done),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    // Count pixels handed to the engine.
    always @(posedge clk) begin
        if (pix_out_valid) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        s_valid        = 1'b0;
        s_pixel        = 8'h00;
        line_done_intr = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_credits", credits, 4);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err", err_overflow, 0);

        // Frame A: continuous valid, no interrupts -> stall after 4 lines
        rst   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b1;
        s_pixel = 8'hA5;
        #1;
        check("pix_passthru", pix_out, 8'hA5);
        check("pix_valid_feed", pix_out_valid, 1);
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) check($sformatf("s2_credits_%0d", i), credits, 4 - i / 8);
            if (i == 31) check("s2_ready_before_stall", s_ready, 1);
            if (i == 32 || i == 39) check($sformatf("s2_ready_stalled_%0d", i), s_ready, 0);
            if (i == 0) check("s2_busy", busy, 1);
            @(negedge clk);
        end
        check("s2_accepted", acc_cnt, 32);

        // One interrupt releases one line
        line_done_intr = 1'b1;
        @(negedge clk);
        line_done_intr = 1'b0;
        check("s3_credits_after_intr", credits, 1);
        check("s3_ready_after_intr", s_ready, 1);
        repeat (8) @(negedge clk);
        check("s3_credits_restall", credits, 0);
        check("s3_ready_restall", s_ready, 0);
        @(negedge clk);
        check("s3_accepted", acc_cnt, 40);

        // Mid-frame abort
        s_valid = 1'b0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_credits", credits, 4);
        check("abort_ready", s_ready, 0);
        rst = 1'b0;

        // Frame B: full frame, interrupts at line end (same cycle), mid-line, and in DRAIN
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b1;
        base    = acc_cnt;
        for (int i = 0; i < 56; i++) begin
            line_done_intr = (i == 23 || i == 27 || i == 50 || i == 53);
            if (i == 24) begin
                check("s4_credits_simul", credits, 2);
                check("s4_ready_simul", s_ready, 1);
            end
            if (i == 28) check("s5_credits_mid", credits, 3);
            if (i == 48) begin
                check("s5_drain_busy", busy, 1);
                check("s5_drain_ready", s_ready, 0);
                check("s5_drain_credits", credits, 0);
                check("s5_frame_pixels", acc_cnt - base, 48);
                check("s5_no_err", err_overflow, 0);
            end
            if (i == 53) check("s5_fd_early", frame_done, 0);
            if (i == 54) begin
                check("s5_fd_pulse", frame_done, 1);
                check("s5_done_busy", busy, 0);
                check("s5_done_credits", credits, 2);
            end
            if (i == 55) check("s5_fd_once", frame_done, 0);
            @(negedge clk);
        end
        line_done_intr = 1'b0;
        check("s5_idle_busy", busy, 0);
        check("s5_idle_pixels", acc_cnt - base, 48);

        // Second start begins a fresh frame
        s_valid = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s5_restart_credits", credits, 4);
        check("s5_restart_busy", busy, 1);
        check("s5_restart_ready", s_ready, 1);

        // Interrupt at full credits -> sticky overflow
        line_done_intr = 1'b1;
        @(negedge clk);
        line_done_intr = 1'b0;
        check("s6_err_set", err_overflow, 1);
        check("s6_credits_full", credits, 4);
        @(negedge clk);
        check("s6_err_sticky", err_overflow, 1);
        base    = acc_cnt;
        s_valid = 1'b1;
        repeat (5) @(negedge clk);
        s_valid = 1'b0;
        check("s6_partial_line", acc_cnt - base, 5);
        check("s6_err_still", err_overflow, 1);

        // Reset mid-line clears everything, including the error
        rst = 1'b1;
        repeat (2) @(negedge clk);
        s_valid = 1'b1;
        #1;
        check("s6_rst_ready", s_ready, 0);
        check("s6_rst_pix_valid", pix_out_valid, 0);
        check("s6_rst_credits", credits, 4);
        check("s6_rst_busy", busy, 0);
        check("s6_rst_fd", frame_done, 0);
        check("s6_rst_err", err_overflow, 0);
        rst     = 1'b0;
        s_valid = 1'b0;

        // After reset a line still needs exactly W pixels to consume a credit
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b1;
        repeat (7) @(negedge clk);
        check("post_rst_7px", credits, 4);
        @(negedge clk);
        check("post_rst_8px", credits, 3);
        s_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_feed_scheduler.md
Name: line_feed_scheduler

Overview:
- Credit-based pixel feeder that sits between the upstream pixel source and the 3x3 line-buffer window engine.
- Admits one frame of IMG_WIDTH x IMG_HEIGHT 8-bit pixels. Each completed line consumes one of NUM_LINE_BUFS buffer credits; each line-done interrupt from the engine returns one credit.
- Stalls the source when no buffer is free, so no buffered line is ever overwritten before it is consumed.
- Sequences frame start, feed, drain and frame completion.

Parameters:
- IMG_WIDTH, 512, pixels per line.
- IMG_HEIGHT, 512, lines per frame; must be >= 3.
- NUM_LINE_BUFS, 4, line buffers in the engine, which is the initial credit count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- s_pixel  in  8  upstream pixel.
- s_valid  in  1  upstream pixel valid.
- s_ready  out  1  scheduler can accept a pixel.
- pix_out  out  8  pixel to engine (pass-through of s_pixel).
- pix_out_valid  out  1  pixel accepted this cycle (s_valid & s_ready).
- line_done_intr  in  1  engine pulse: one output line finished, one buffer freed.
- credits  out  clog2(NUM_LINE_BUFS+1)  free line buffers.
- busy  out  1  high in FEED and DRAIN.
- frame_done  out  1  one-cycle pulse at frame completion.
- err_overflow  out  1  sticky; set by an interrupt received with credits == NUM_LINE_BUFS.

Behaviour:
- Reset values:
  - State IDLE.
  - credits = NUM_LINE_BUFS.
  - col_cnt, lines_written, lines_processed = 0.
  - s_ready, busy, frame_done, err_overflow = 0.
  - pix_out_valid = 0.
- Register widths:
  - col_cnt: clog2(IMG_WIDTH).
  - Line counters: clog2(IMG_HEIGHT+1).
- Pixel path timing:
  - pix_out = s_pixel, with zero latency (combinational).
  - pix_out_valid = s_valid & s_ready.
  - s_ready = (state == FEED) & (credits != 0). It is a function of registered state only and never depends on s_valid.
- Accept:
  - A cycle with s_valid & s_ready accepts a pixel and increments col_cnt.
  - On acceptance at col_cnt == IMG_WIDTH-1: col_cnt wraps to 0, lines_written increments and a credit is consumed.
- Credit update each cycle:
  - credits += intr_ok, and credits -= line_complete.
  - If both events occur in the same cycle, credits is unchanged.
  - intr_ok = line_done_intr & busy & (credits != NUM_LINE_BUFS, or line_complete in the same cycle).
  - An interrupt that arrives while credits == NUM_LINE_BUFS with no line_complete is dropped and sets err_overflow.
  - An interrupt in IDLE or DONE is ignored and does not set the error.
- lines_processed increments on each intr_ok.
- State machine:
  - IDLE: on start, clear the counters, set credits = NUM_LINE_BUFS and go to FEED. A start pulse in any other state is ignored.
  - FEED: busy = 1. On acceptance of the last pixel of line IMG_HEIGHT-1, go to DRAIN.
  - DRAIN: busy = 1 and s_ready = 0. When lines_processed reaches IMG_HEIGHT-2 (counting an intr_ok in the current cycle), go to DONE.
  - DONE: frame_done = 1 for exactly one cycle, busy = 0, then go to IDLE.
- Wrap, full and empty rules:
  - credits never goes below 0 or above NUM_LINE_BUFS.
  - When credits == 0, s_ready drops on the cycle after the consuming acceptance.
  - s_ready returns on the cycle after an intr_ok.
- err_overflow is cleared only by rst.
- Reset mid-frame aborts immediately. All counters return to their reset values and the engine is reset through the shared rst.

Test Plan:
1. Bench parameters: W=8, H=6, N=4. Assert rst for 2 cycles → s_ready=0, credits=4, busy=0, frame_done=0, err_overflow=0.
2. Pulse start, then hold s_valid=1 continuously with no interrupts → exactly 32 pixels accepted. Credits steps 4,3,2,1,0 at pixels 8/16/24/32. s_ready=0 from the cycle after pixel 32 and stays low.
3. From the stall in scenario 2, pulse line_done_intr once → credits=1 and s_ready=1 on the next cycle. 8 more pixels are accepted, then credits=0 and the source stalls again.
4. Pulse line_done_intr on the same cycle the 8th pixel of a line is accepted (credits=2) → credits remains 2 and s_ready stays high.
5. Full frame: 48 pixels with 4 interrupts spread across FEED and DRAIN → DRAIN is entered after pixel 48. frame_done pulses exactly 1 cycle, on the cycle after the 4th interrupt. busy=0 afterwards, and a second start begins a new frame with credits=4.
6. Pulse line_done_intr during FEED with credits=4 → err_overflow=1 (sticky), credits stays 4. Then assert rst mid-line (col_cnt=5) → all outputs return to reset values and err_overflow clears.
